// File: rtl/alu_sched_pkg.sv
// Shared opcode and state definitions for the ALU request scheduler.
package alu_sched_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10,
        ST_RESP = 2'b11
    } state_e;

endpackage

// File: rtl/booth_iter_mul.sv
// Iterative radix-2 Booth multiplier: one add/sub plus arithmetic shift per clock.
// The accumulator carries one guard bit so neither the most negative signed
// operand nor a full-range unsigned multiplicand can overflow it. Unsigned
// mode treats the multiplier as signed during the W iterations and adds back
// a<<W when the multiplier MSB was set.
module booth_iter_mul #(
    parameter int W      = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] prod
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [2*W+1:0] p_q;
    logic [2*W+1:0] pNext;
    logic [W:0]     m_q;
    logic [W:0]     acc;
    logic [W:0]     accSum;
    logic [CW-1:0]  cnt_q;
    logic           run_q;
    logic           done_q;
    logic           bMsb_q;
    logic [2*W-1:0] corr;

    assign acc = p_q[2*W+1:W+1];

    // Booth recoding of the two low bits picks add, subtract or pass, then shift right arithmetically
    always_comb begin
        accSum = acc;
        case (p_q[1:0])
            2'b01:   accSum = acc + m_q;
            2'b10:   accSum = acc - m_q;
            default: accSum = acc;
        endcase
        pNext = {accSum[W], accSum, p_q[W:1]};
    end

    // Load operands on start, then run exactly W iterations and pulse done afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
            bMsb_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                p_q    <= {{(W+1){1'b0}}, b, 1'b0};
                m_q    <= SIGNED ? {a[W-1], a} : {1'b0, a};
                cnt_q  <= '0;
                run_q  <= 1'b1;
                bMsb_q <= b[W-1];
            end else if (run_q) begin
                p_q   <= pNext;
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(W-1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign corr = (!SIGNED && bMsb_q) ? {m_q[W-1:0], {W{1'b0}}} : '0;
    assign prod = p_q[2*W:1] + corr;
    assign done = done_q;

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU datapath between two requesters with round-robin arbitration.
// One operation is in flight at a time; multiplies go through the iterative
// Booth unit, everything else completes in a single EXEC cycle.
module alu_req_scheduler
    import alu_sched_pkg::*;
#(
    parameter int W          = 32,
    parameter bit MUL_SIGNED = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [2:0]     req0_op,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [2:0]     req1_op,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*W-1:0] rsp_result,
    output logic           rsp_err,
    output logic           busy
);

    state_e         state_q, state_d;
    logic           lastGnt_q;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q, b_q;
    logic           id_q;
    logic           rspId_q;
    logic           rspErr_q;
    logic [2*W-1:0] rspResult_q;

    logic           gnt0, gnt1, anyGnt;
    logic [2:0]     selOp;
    logic [W-1:0]   selA, selB;
    logic           mulStart, mulDone;
    logic [2*W-1:0] mulProd;
    logic [W-1:0]   aluRes;

    // Round-robin grant, only offered while idle; a tie goes to the requester not served last
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && state_q == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt0 = lastGnt_q;
                gnt1 = !lastGnt_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign anyGnt   = gnt0 | gnt1;
    assign selOp    = gnt1 ? req1_op : req0_op;
    assign selA     = gnt1 ? req1_a  : req0_a;
    assign selB     = gnt1 ? req1_b  : req0_b;
    assign mulStart = anyGnt && (selOp == OP_MUL);

    booth_iter_mul #(
        .W      (W),
        .SIGNED (MUL_SIGNED)
    ) uMul (
        .clk   (clk),
        .rst   (rst),
        .start (mulStart),
        .a     (selA),
        .b     (selB),
        .done  (mulDone),
        .prod  (mulProd)
    );

    // Next-state logic: single-cycle ops via EXEC, multiplies wait for the Booth unit
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (anyGnt) state_d = (selOp == OP_MUL) ? ST_MUL : ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_MUL:  if (mulDone) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Combinational ALU for the non-multiply opcodes; shifts ignore B
    always_comb begin
        aluRes = '0;
        case (op_q)
            OP_ADD:  aluRes = a_q + b_q;
            OP_SUB:  aluRes = a_q - b_q;
            OP_AND:  aluRes = a_q & b_q;
            OP_XOR:  aluRes = a_q ^ b_q;
            OP_SRL:  aluRes = a_q >> 1;
            OP_SLL:  aluRes = a_q << 1;
            default: aluRes = '0;
        endcase
    end

    // Capture the granted request, then register the response; RESP holds it until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            lastGnt_q   <= 1'b1;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rspId_q     <= 1'b0;
            rspErr_q    <= 1'b0;
            rspResult_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (anyGnt) begin
                        op_q      <= selOp;
                        a_q       <= selA;
                        b_q       <= selB;
                        id_q      <= gnt1;
                        lastGnt_q <= gnt1;
                    end
                end
                ST_EXEC: begin
                    rspResult_q <= {{W{1'b0}}, aluRes};
                    rspErr_q    <= (op_q == OP_ILL);
                    rspId_q     <= id_q;
                end
                ST_MUL: begin
                    if (mulDone) begin
                        rspResult_q <= mulProd;
                        rspErr_q    <= 1'b0;
                        rspId_q     <= id_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = rspId_q;
    assign rsp_result = rspResult_q;
    assign rsp_err    = rspErr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Self-checking bench for alu_req_scheduler: directed scenarios followed by
// randomized transactions, all checked against an arithmetic reference model.
module tb_alu_req_scheduler;
    import alu_sched_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [2:0]     req0_op, req1_op;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [2*W-1:0] rsp_result;

    int total   = 0;
    int bad     = 0;
    int lastGnt = 1;
    bit flag;

    always #5 clk = ~clk;

    alu_req_scheduler #(.W(W), .MUL_SIGNED(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    // Reference result computed straight from the opcode table
    function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        case (op)
            3'b000:  return {32'h0, a + b};
            3'b001:  return {32'h0, a - b};
            3'b010: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return 64'(sa * sb);
            end
            3'b011:  return {32'h0, a & b};
            3'b100:  return {32'h0, a ^ b};
            3'b101:  return {32'h0, a >> 1};
            3'b110:  return {32'h0, a << 1};
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit v0, input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                                 input bit v1, input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(0, 3'b000, 0, 0, 0, 3'b000, 0, 0);
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        lastGnt = 1;
    endtask

    // One full transaction: grant, latency, response contents, stall hold, handshake.
    // Called at 1ns after a rising edge with the DUT idle; returns at the same phase.
    task automatic runOp(input bit v0, input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input bit v1, input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                         input int stall);
        int g, expLat, lat;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [63:0] expRes, snapRes;
        logic        snapId, snapErr;
        bit          sawBad, stable;

        applyStimulus(v0, op0, a0, b0, v1, op1, a1, b1);
        g      = (v0 && v1) ? (1 - lastGnt) : (v1 ? 1 : 0);
        op     = (g == 1) ? op1 : op0;
        a      = (g == 1) ? a1 : a0;
        b      = (g == 1) ? b1 : b0;
        expRes = refResult(op, a, b);
        expLat = (op == 3'b010) ? W + 2 : 2;

        @(negedge clk);
        checkOutput("grant", {62'h0, req1_ready, req0_ready}, (g == 1) ? 64'h2 : 64'h1);
        lastGnt = g;

        @(posedge clk); #1;
        if (g == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;

        lat    = 1;
        sawBad = 1'b0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && lat < 100) begin
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) sawBad = 1'b1;
            @(posedge clk); #1;
            lat++;
            @(negedge clk);
        end
        checkOutput("latency", lat, expLat);
        if (rsp_valid !== 1'b1) begin
            doReset();
            return;
        end

        checkOutput("rsp_id", {63'h0, rsp_id}, g);
        checkOutput("rsp_result", rsp_result, expRes);
        checkOutput("rsp_err", {63'h0, rsp_err}, (op == 3'b111) ? 64'h1 : 64'h0);

        snapId  = rsp_id;
        snapRes = rsp_result;
        snapErr = rsp_err;
        stable  = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_id !== snapId || rsp_result !== snapRes || rsp_err !== snapErr)
                stable = 1'b0;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) sawBad = 1'b1;
        end
        if (stall > 0) checkOutput("stall_hold", {63'h0, stable}, 64'h1);

        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) sawBad = 1'b1;
        checkOutput("no_ready_while_busy", {63'h0, sawBad}, 64'h0);

        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checkOutput("idle_after_rsp", {62'h0, rsp_valid, busy}, 64'h0);
    endtask

    // Hard time limit so the run always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        bit          v0, v1;
        logic [2:0]  o0, o1;
        logic [31:0] x0, y0, x1, y1;
        int          vsel;

        rst       = 1'b1;
        rsp_ready = 1'b0;
        applyStimulus(1, OP_ADD, 1, 2, 1, OP_SUB, 3, 4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        checkOutput("reset_rsp_id", {63'h0, rsp_id}, 64'h0);
        checkOutput("reset_rsp_result", rsp_result, 64'h0);
        checkOutput("reset_rsp_err", {63'h0, rsp_err}, 64'h0);
        checkOutput("reset_busy", {63'h0, busy}, 64'h0);
        checkOutput("reset_readys", {62'h0, req1_ready, req0_ready}, 64'h0);
        @(posedge clk); #1;
        applyStimulus(0, 3'b000, 0, 0, 0, 3'b000, 0, 0);
        rst     = 1'b0;
        lastGnt = 1;
        @(posedge clk); #1;

        $display("[TB] single add with wrap");
        runOp(1, OP_ADD, 32'hFFFF_FFFF, 32'h1, 0, OP_ADD, 0, 0, 0);

        $display("[TB] signed multiply on requester 1");
        runOp(0, OP_ADD, 0, 0, 1, OP_MUL, 32'hFFFF_FFFE, 32'h3, 0);

        $display("[TB] ties after reset alternate");
        runOp(1, OP_ADD, 1, 1, 1, OP_SUB, 5, 2, 0);
        runOp(1, OP_ADD, 1, 1, 1, OP_SUB, 5, 2, 0);
        runOp(1, OP_ADD, 1, 1, 1, OP_SUB, 5, 2, 0);

        $display("[TB] back-pressure on xor");
        runOp(1, OP_ADD, 9, 9, 1, OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 10);

        $display("[TB] illegal opcode and shifts");
        runOp(1, OP_ILL, 32'h1234_5678, 32'h9, 0, OP_ADD, 0, 0, 0);
        runOp(1, OP_SRL, 32'h8000_0001, 32'hDEAD_BEEF, 0, OP_ADD, 0, 0, 0);
        runOp(0, OP_ADD, 0, 0, 1, OP_SLL, 32'h8000_0001, 32'h5555_5555, 2);

        $display("[TB] reset during multiply");
        applyStimulus(1, OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 0, OP_ADD, 0, 0);
        @(negedge clk);
        checkOutput("midmul_grant", {62'h0, req1_ready, req0_ready}, 64'h1);
        lastGnt = 0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        lastGnt = 1;
        checkOutput("midmul_idle", {62'h0, rsp_valid, busy}, 64'h0);
        flag = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) flag = 1'b1;
        end
        checkOutput("midmul_no_rsp", {63'h0, flag}, 64'h0);
        @(posedge clk); #1;
        runOp(1, OP_ADD, 7, 8, 1, OP_ADD, 100, 200, 0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            vsel = $urandom_range(1, 3);
            v0   = vsel[0];
            v1   = vsel[1];
            o0   = 3'($urandom_range(0, 7));
            o1   = 3'($urandom_range(0, 7));
            x0   = pickOperand();
            y0   = pickOperand();
            x1   = pickOperand();
            y1   = pickOperand();
            runOp(v0, o0, x0, y0, v1, o1, x1, y1, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
